// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: abstract op kinds,
// MIPS32 opcode/funct/REGIMM constants and the pure encode function.
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLLV, OP_SRLV, OP_SRAV, OP_SLL, OP_SRL, OP_SRA,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ,
        OP_J, OP_JAL, OP_JR, OP_JALR
    } op_kind_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000, OPC_REGIMM = 6'b000001;
    localparam logic [5:0] OPC_J    = 6'b000010, OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100, OPC_BNE  = 6'b000101;
    localparam logic [5:0] OPC_BLEZ = 6'b000110, OPC_BGTZ = 6'b000111;
    localparam logic [5:0] OPC_ADDI = 6'b001000, OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI = 6'b001010, OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI = 6'b001100, OPC_ORI  = 6'b001101;
    localparam logic [5:0] OPC_XORI = 6'b001110, OPC_LUI  = 6'b001111;
    localparam logic [5:0] OPC_LB   = 6'b100000, OPC_LH   = 6'b100001;
    localparam logic [5:0] OPC_LW   = 6'b100011, OPC_LBU  = 6'b100100;
    localparam logic [5:0] OPC_LHU  = 6'b100101, OPC_SB   = 6'b101000;
    localparam logic [5:0] OPC_SH   = 6'b101001, OPC_SW   = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JR   = 6'b001000, FN_JALR = 6'b001001;
    localparam logic [5:0] FN_ADD  = 6'b100000, FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010, FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100, FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110, FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010, FN_SLTU = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001;

    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;

    // Fields an encoding does not use are simply left out of the concatenation.
    function automatic enc_t encode_instr(input logic [5:0] kind,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [15:0] imm, input logic [25:0] target);
        enc_t e;
        e.ok   = 1'b1;
        e.word = '0;
        case (kind)
            OP_NOP:   e.word = '0;
            OP_ADD:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_ADD};
            OP_ADDU:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_ADDU};
            OP_SUB:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SUB};
            OP_SUBU:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SUBU};
            OP_AND:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_AND};
            OP_OR:    e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_OR};
            OP_XOR:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_XOR};
            OP_NOR:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_NOR};
            OP_SLT:   e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SLT};
            OP_SLTU:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SLTU};
            OP_SLLV:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SLLV};
            OP_SRLV:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SRLV};
            OP_SRAV:  e.word = {OPC_SPECIAL, rs, rt, rd, 5'b0, FN_SRAV};
            OP_SLL:   e.word = {OPC_SPECIAL, 5'b0, rt, rd, shamt, FN_SLL};
            OP_SRL:   e.word = {OPC_SPECIAL, 5'b0, rt, rd, shamt, FN_SRL};
            OP_SRA:   e.word = {OPC_SPECIAL, 5'b0, rt, rd, shamt, FN_SRA};
            OP_ADDI:  e.word = {OPC_ADDI, rs, rt, imm};
            OP_ADDIU: e.word = {OPC_ADDIU, rs, rt, imm};
            OP_SLTI:  e.word = {OPC_SLTI, rs, rt, imm};
            OP_SLTIU: e.word = {OPC_SLTIU, rs, rt, imm};
            OP_ANDI:  e.word = {OPC_ANDI, rs, rt, imm};
            OP_ORI:   e.word = {OPC_ORI, rs, rt, imm};
            OP_XORI:  e.word = {OPC_XORI, rs, rt, imm};
            OP_LUI:   e.word = {OPC_LUI, 5'b0, rt, imm};
            OP_LB:    e.word = {OPC_LB, rs, rt, imm};
            OP_LH:    e.word = {OPC_LH, rs, rt, imm};
            OP_LW:    e.word = {OPC_LW, rs, rt, imm};
            OP_LBU:   e.word = {OPC_LBU, rs, rt, imm};
            OP_LHU:   e.word = {OPC_LHU, rs, rt, imm};
            OP_SB:    e.word = {OPC_SB, rs, rt, imm};
            OP_SH:    e.word = {OPC_SH, rs, rt, imm};
            OP_SW:    e.word = {OPC_SW, rs, rt, imm};
            OP_BEQ:   e.word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:   e.word = {OPC_BNE, rs, rt, imm};
            OP_BLEZ:  e.word = {OPC_BLEZ, rs, 5'b0, imm};
            OP_BGTZ:  e.word = {OPC_BGTZ, rs, 5'b0, imm};
            OP_BLTZ:  e.word = {OPC_REGIMM, rs, RT_BLTZ, imm};
            OP_BGEZ:  e.word = {OPC_REGIMM, rs, RT_BGEZ, imm};
            OP_J:     e.word = {OPC_J, target};
            OP_JAL:   e.word = {OPC_JAL, target};
            OP_JR:    e.word = {OPC_SPECIAL, rs, 15'b0, FN_JR};
            OP_JALR:  e.word = {OPC_SPECIAL, rs, 5'b0, rd, 5'b0, FN_JALR};
            default:  e.ok   = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Small synchronous FIFO: extra-bit pointers give full/empty without a counter,
// head word is presented combinationally on rdata.
module instr_encoder_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    // Pointer next-state; flush empties the queue regardless of push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    // Storage is not reset; contents are only observed behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS32 instruction encoder: packs requests into machine words,
// queues them and writes them to consecutive IM word addresses.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [5:0]        op_kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W:0]   word_count,
    output logic              err
);
    import instr_encoder_pkg::*;

    enc_t              enc;
    logic              accept, push, pop;
    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_rdata;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    assign enc      = encode_instr(op_kind, rs, rt, rd, shamt, imm, target);
    // op_ready depends only on registered FIFO state, never on wr_ready.
    assign op_ready = !fifo_full && !start;
    assign accept   = op_valid && op_ready;
    assign push     = accept && enc.ok;
    assign wr_valid = !fifo_empty;
    // A write handshake in the start cycle is dropped along with the queue.
    assign pop      = wr_valid && wr_ready && !start;

    assign wr_data    = wr_valid ? fifo_rdata : '0;
    assign wr_addr    = addr_q;
    assign word_count = count_q;
    assign err        = err_q;

    instr_encoder_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (push),
        .wdata (enc.word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address wraps naturally; word count saturates; err is sticky until start.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        if (start) begin
            addr_d  = base_addr;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (pop) begin
                addr_d = addr_q + ADDR_W'(1);
                if (count_q != '1) count_d = count_q + (ADDR_W+1)'(1);
            end
            if (accept && !enc.ok) err_d = 1'b1;
        end
    end

    // Write-side state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus random traffic against a
// queue-based reference model that encodes from the MIPS32 field rules.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int CNT_MAX = (1 << (ADDR_W + 1)) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [5:0]        op_kind = '0;
    logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [15:0]       imm = '0;
    logic [25:0]       target = '0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W:0]   word_count;
    logic              err;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .word_count(word_count), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit [31:0] m_q[$];
    int        m_addr = 0;
    int        m_count = 0;
    bit        m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference encoder: builds words arithmetically from numeric field positions.
    function automatic bit [31:0] ref_word(input logic [5:0] k, input logic [4:0] s_i,
                                           input logic [4:0] t_i, input logic [4:0] d_i,
                                           input logic [4:0] sh_i, input logic [15:0] im_i,
                                           input logic [25:0] tg_i, output bit ok);
        bit [31:0] s, t, d, sh, im, tg, r3, itp;
        s  = 32'(s_i) << 21;
        t  = 32'(t_i) << 16;
        d  = 32'(d_i) << 11;
        sh = 32'(sh_i) << 6;
        im = 32'(im_i);
        tg = 32'(tg_i);
        r3 = s | t | d;
        itp = s | t | im;
        ok = 1'b1;
        case (k)
            OP_NOP:   return 0;
            OP_ADD:   return r3 | 32;
            OP_ADDU:  return r3 | 33;
            OP_SUB:   return r3 | 34;
            OP_SUBU:  return r3 | 35;
            OP_AND:   return r3 | 36;
            OP_OR:    return r3 | 37;
            OP_XOR:   return r3 | 38;
            OP_NOR:   return r3 | 39;
            OP_SLT:   return r3 | 42;
            OP_SLTU:  return r3 | 43;
            OP_SLLV:  return r3 | 4;
            OP_SRLV:  return r3 | 6;
            OP_SRAV:  return r3 | 7;
            OP_SLL:   return t | d | sh | 0;
            OP_SRL:   return t | d | sh | 2;
            OP_SRA:   return t | d | sh | 3;
            OP_ADDI:  return (8 << 26) | itp;
            OP_ADDIU: return (9 << 26) | itp;
            OP_SLTI:  return (10 << 26) | itp;
            OP_SLTIU: return (11 << 26) | itp;
            OP_ANDI:  return (12 << 26) | itp;
            OP_ORI:   return (13 << 26) | itp;
            OP_XORI:  return (14 << 26) | itp;
            OP_LUI:   return (15 << 26) | t | im;
            OP_LB:    return (32 << 26) | itp;
            OP_LH:    return (33 << 26) | itp;
            OP_LW:    return (35 << 26) | itp;
            OP_LBU:   return (36 << 26) | itp;
            OP_LHU:   return (37 << 26) | itp;
            OP_SB:    return (40 << 26) | itp;
            OP_SH:    return (41 << 26) | itp;
            OP_SW:    return (43 << 26) | itp;
            OP_BEQ:   return (4 << 26) | itp;
            OP_BNE:   return (5 << 26) | itp;
            OP_BLEZ:  return (6 << 26) | s | im;
            OP_BGTZ:  return (7 << 26) | s | im;
            OP_BLTZ:  return (1 << 26) | s | im;
            OP_BGEZ:  return (1 << 26) | s | (1 << 16) | im;
            OP_J:     return (2 << 26) | tg;
            OP_JAL:   return (3 << 26) | tg;
            OP_JR:    return s | 8;
            OP_JALR:  return s | d | 9;
            default: begin
                ok = 1'b0;
                return 0;
            end
        endcase
    endfunction

    task automatic compare_outputs();
        check("op_ready", op_ready, (!start && m_q.size() < DEPTH) ? 1 : 0);
        check("wr_valid", wr_valid, (m_q.size() > 0) ? 1 : 0);
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, (m_q.size() > 0) ? m_q[0] : 0);
        check("word_count", word_count, m_count);
        check("err", err, m_err);
    endtask

    // Called at a negedge right after inputs are set: model the coming edge, then check.
    task automatic tick();
        bit        ok;
        bit [31:0] w;
        #1;
        if (start) begin
            m_q.delete();
            m_addr  = base_addr;
            m_count = 0;
            m_err   = 1'b0;
        end else begin
            bit can_accept;
            can_accept = (m_q.size() < DEPTH);
            if (wr_ready && m_q.size() > 0) begin
                void'(m_q.pop_front());
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                if (m_count < CNT_MAX) m_count++;
            end
            if (op_valid && can_accept) begin
                w = ref_word(op_kind, rs, rt, rd, shamt, imm, target, ok);
                if (ok) m_q.push_back(w);
                else m_err = 1'b1;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_req(input logic [5:0] k, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                           input logic [25:0] tg);
        op_kind = k; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_op_ready"}, op_ready, 1);
        check({tag, "_wr_valid"}, wr_valid, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First word one cycle after accept
        do_start(10'h010);
        wr_ready = 1'b1;
        set_req(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        check("addu_data", wr_data, 32'h0022_1821);
        check("addu_addr", wr_addr, 32'h010);
        tick();

        // Back-to-back ori / lw / sll
        do_start(10'h010);
        op_valid = 1'b1;
        set_req(OP_ORI, 5'd0, 5'd8, 5'd0, 5'd0, 16'h1234, 26'h0);
        tick();
        set_req(OP_LW, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0);
        tick();
        set_req(OP_SLL, 5'd0, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("b2b_count", word_count, 3);
        check("b2b_addr", wr_addr, 32'h013);

        // bgez and jal words
        wr_ready = 1'b0;
        op_valid = 1'b1;
        set_req(OP_BGEZ, 5'd4, 5'd7, 5'd9, 5'd3, 16'hFFFF, 26'h3FFFFFF);
        tick();
        set_req(OP_JAL, 5'd5, 5'd6, 5'd7, 5'd8, 16'hABCD, 26'h0100000);
        tick();
        op_valid = 1'b0;
        check("bgez_data", wr_data, 32'h0481_FFFF);
        wr_ready = 1'b1;
        tick();
        check("jal_data", wr_data, 32'h0C10_0000);
        tick();

        // Fill to full with the write side stalled, then release
        wr_ready = 1'b0;
        op_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_req(OP_ADD, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 26'h0);
            tick();
        end
        check("full_op_ready", op_ready, 0);
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        wr_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("full_drained", wr_valid, 0);

        // Unsupported op between two valid ops
        do_start(10'h020);
        op_valid = 1'b1;
        set_req(OP_SUB, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        set_req(6'd60, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        set_req(OP_OR, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("bad_err", err, 1);
        check("bad_count", word_count, 2);
        check("bad_addr", wr_addr, 32'h022);
        do_start(10'h000);
        check("start_err", err, 0);
        check("start_count", word_count, 0);

        // Address wrap
        do_start(10'h3FF);
        wr_ready = 1'b0;
        op_valid = 1'b1;
        set_req(OP_XORI, 5'd2, 5'd3, 5'd0, 5'd0, 16'h5555, 26'h0);
        tick();
        set_req(OP_BNE, 5'd7, 5'd8, 5'd0, 5'd0, 16'h8000, 26'h0);
        tick();
        op_valid = 1'b0;
        check("wrap_addr_hi", wr_addr, 32'h3FF);
        wr_ready = 1'b1;
        tick();
        check("wrap_addr_lo", wr_addr, 32'h000);
        tick();

        // Async reset while a write is pending
        wr_ready = 1'b0;
        op_valid = 1'b1;
        set_req(OP_JR, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        tick();
        op_valid = 1'b0;
        check("pre_rst_valid", wr_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async_rst");
        m_q.delete();
        m_addr = 0;
        m_count = 0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Word count saturation
        do_start(10'h100);
        wr_ready = 1'b1;
        op_valid = 1'b1;
        set_req(OP_NOP, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < CNT_MAX + 20; i++) tick();
        op_valid = 1'b0;
        tick();
        tick();
        check("count_sat", word_count, CNT_MAX);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            op_valid  = ($urandom_range(0, 3) != 0);
            set_req(6'($urandom_range(0, 47)), 5'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 16'($urandom), 26'($urandom));
            wr_ready  = ($urandom_range(0, 2) != 0);
            start     = ($urandom_range(0, 149) == 0);
            base_addr = ADDR_W'($urandom);
            tick();
            start = 1'b0;
        end
        op_valid = 1'b0;
        wr_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
